// File: rtl/soc_axi_sram_master.sv
// AXI4 initiator: turns one request plus a write/read beat stream into a single
// AXI4 burst, with per-transaction completion status.
module soc_axi_sram_master #(
  parameter logic [3:0] AXI_ID = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [1:0]  req_burst,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_last,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        done,
  output logic [1:0]  done_resp,
  output logic [3:0]  axi_m_awid,
  output logic [31:0] axi_m_awaddr,
  output logic [7:0]  axi_m_awlen,
  output logic [2:0]  axi_m_awsize,
  output logic [1:0]  axi_m_awburst,
  output logic [0:0]  axi_m_awuser,
  output logic        axi_m_awvalid,
  input  logic        axi_m_awready,
  output logic [31:0] axi_m_wdata,
  output logic [3:0]  axi_m_wstrb,
  output logic        axi_m_wlast,
  output logic        axi_m_wvalid,
  input  logic        axi_m_wready,
  input  logic [3:0]  axi_m_bid,
  input  logic [1:0]  axi_m_bresp,
  input  logic        axi_m_bvalid,
  output logic        axi_m_bready,
  output logic [3:0]  axi_m_arid,
  output logic [31:0] axi_m_araddr,
  output logic [7:0]  axi_m_arlen,
  output logic [2:0]  axi_m_arsize,
  output logic [1:0]  axi_m_arburst,
  output logic [0:0]  axi_m_aruser,
  output logic        axi_m_arvalid,
  input  logic        axi_m_arready,
  input  logic [3:0]  axi_m_rid,
  input  logic [31:0] axi_m_rdata,
  input  logic [1:0]  axi_m_rresp,
  input  logic        axi_m_rlast,
  input  logic        axi_m_rvalid,
  output logic        axi_m_rready
);

  typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_t;

  state_t      state, state_nxt;
  logic        aw_valid_r, ar_valid_r, done_r;
  logic [1:0]  done_resp_r, resp_r, resp_rd_nxt;
  logic [7:0]  beat_cnt, len_r;
  logic [31:0] addr_r;
  logic [1:0]  burst_r;
  logic        at_last, w_hs, r_hs;
  logic        unused_ids;

  // Counter saturates so a 256-beat burst ends at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign at_last    = (beat_cnt == len_r);
  assign w_hs       = axi_m_wvalid & axi_m_wready;
  assign r_hs       = rd_valid & rd_ready;
  assign unused_ids = ^{axi_m_bid, axi_m_rid};

  always_comb begin
    state_nxt    = state;
    req_ready    = 1'b0;
    wr_ready     = 1'b0;
    axi_m_wvalid = 1'b0;
    axi_m_bready = 1'b0;
    axi_m_rready = 1'b0;
    rd_valid     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_write ? AW : AR;
      end
      AW: if (axi_m_awready) state_nxt = W;
      W: begin
        axi_m_wvalid = wr_valid;
        wr_ready     = axi_m_wready;
        if (wr_valid && axi_m_wready && at_last) state_nxt = B;
      end
      B: begin
        axi_m_bready = 1'b1;
        if (axi_m_bvalid) state_nxt = IDLE;
      end
      AR: if (axi_m_arready) state_nxt = R;
      R: begin
        rd_valid     = axi_m_rvalid;
        axi_m_rready = rd_ready;
        if (axi_m_rvalid && rd_ready && axi_m_rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Worst response wins; an rlast that disagrees with the requested length is a slave error.
  always_comb begin
    resp_rd_nxt = (axi_m_rresp > resp_r) ? axi_m_rresp : resp_r;
    if (axi_m_rlast != at_last) resp_rd_nxt = 2'b10;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      aw_valid_r  <= 1'b0;
      ar_valid_r  <= 1'b0;
      beat_cnt    <= 8'd0;
      resp_r      <= 2'b00;
      done_r      <= 1'b0;
      done_resp_r <= 2'b00;
    end else begin
      state  <= state_nxt;
      done_r <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          aw_valid_r <= req_write;
          ar_valid_r <= ~req_write;
          beat_cnt   <= 8'd0;
          resp_r     <= 2'b00;
        end
        AW: if (axi_m_awready) aw_valid_r <= 1'b0;
        W:  if (w_hs) beat_cnt <= sat_inc(beat_cnt);
        B: if (axi_m_bvalid) begin
          resp_r      <= axi_m_bresp;
          done_r      <= 1'b1;
          done_resp_r <= axi_m_bresp;
        end
        AR: if (axi_m_arready) ar_valid_r <= 1'b0;
        R: if (r_hs) begin
          beat_cnt <= sat_inc(beat_cnt);
          resp_r   <= resp_rd_nxt;
          if (axi_m_rlast) begin
            done_r      <= 1'b1;
            done_resp_r <= resp_rd_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Request fields are plain data; they are only meaningful once a request is latched.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      addr_r  <= req_addr;
      len_r   <= req_len;
      burst_r <= req_burst;
    end
  end

  assign axi_m_awid    = AXI_ID;
  assign axi_m_awaddr  = addr_r;
  assign axi_m_awlen   = len_r;
  assign axi_m_awsize  = 3'b010;
  assign axi_m_awburst = burst_r;
  assign axi_m_awuser  = 1'b0;
  assign axi_m_awvalid = aw_valid_r;
  assign axi_m_wdata   = wr_data;
  assign axi_m_wstrb   = wr_strb;
  assign axi_m_wlast   = (state == W) && at_last;
  assign axi_m_arid    = AXI_ID;
  assign axi_m_araddr  = addr_r;
  assign axi_m_arlen   = len_r;
  assign axi_m_arsize  = 3'b010;
  assign axi_m_arburst = burst_r;
  assign axi_m_aruser  = 1'b0;
  assign axi_m_arvalid = ar_valid_r;
  assign rd_data       = axi_m_rdata;
  assign rd_last       = axi_m_rlast;
  assign done          = done_r;
  assign done_resp     = done_resp_r;

endmodule
